cache_mem_ctrl: RTL and testbench
=================================

// Module: cache_mem_ctrl
// PURPOSE
//  Sequences cache<->memory line transfers on the C2 bus for the L1 cache: on a miss it optionally writes
//  back a dirty victim line, then refills the requested line. Serialises a LINE_BYTES line into BUS_W beats
//  and back, and owns all C2 bus driving so the cache core only issues one request and waits for done.
// PARAMETERS
//  LADDR_W     15   line-address width (19-bit byte address minus 4 offset bits)
//  LINE_BYTES  16   cache line size in bytes
//  BUS_W       16   C2 data bus width in bits; BEATS = LINE_BYTES*8/BUS_W = 8
//  TIMEOUT     1023 max cycles waiting for mem_resp before aborting
// PORTS
//  clk          in   1             clock, all state on posedge
//  rst_n        in   1             asynchronous active-low reset
//  req_valid    in   1             cache requests a miss service
//  req_ready    out  1             controller idle, request accepted when valid&&ready
//  req_wb       in   1             victim is dirty: write back before refill
//  req_wb_addr  in   LADDR_W       victim line address
//  req_wb_data  in   LINE_BYTES*8  victim line data
//  req_rd_addr  in   LADDR_W       line address to refill
//  done_valid   out  1             one-cycle pulse: refill finished (or aborted)
//  done_err     out  1             qualifies done_valid: timeout abort, done_data invalid
//  done_data    out  LINE_BYTES*8  refilled line, stable while done_valid
//  mem_cmd      out  2             C2 command: 0 NOP, 2 READ_LINE, 3 WRITE_LINE
//  mem_addr     out  LADDR_W       C2 line address
//  mem_wdata    out  BUS_W         C2 write beat
//  mem_rdata    in   BUS_W         C2 read beat
//  mem_resp     in   1             C2 RESPONSE from memory
//  proto_err    out  1             sticky: mem_resp seen outside WB_WAIT/RD_WAIT/RD_DATA
// BEHAVIOUR
//  - Reset (async, any state): state IDLE, req_ready=1, all other outputs 0, beat/timeout counters 0,
//    latched request and partial line discarded. proto_err cleared only by reset.
//  - States: IDLE, WB_SEND, WB_WAIT, RD_CMD, RD_WAIT, RD_DATA, DONE.
//  - IDLE: req_ready=1. On valid&&ready latch all req_* inputs; next WB_SEND if req_wb else RD_CMD.
//  - WB_SEND: BEATS cycles; mem_cmd=3, mem_addr=wb_addr held; mem_wdata = beat k = data[k*BUS_W+:BUS_W],
//    k=0 first (little-endian). Then WB_WAIT.
//  - WB_WAIT: mem_cmd=0; wait mem_resp (1-cycle ack) -> RD_CMD.
//  - RD_CMD: one cycle mem_cmd=2, mem_addr=rd_addr -> RD_WAIT.
//  - RD_WAIT: mem_cmd=0; first mem_resp cycle captures beat 0 -> RD_DATA.
//  - RD_DATA: each mem_resp cycle captures next beat into its slot; mem_resp low stalls (index held);
//    after beat BEATS-1 -> DONE. Extra mem_resp beyond BEATS sets proto_err.
//  - DONE: done_valid=1 for exactly one cycle with full line -> IDLE (req_ready=1 next cycle).
//  - Latency (no wb, memory first resp L cycles after READ_LINE): accept edge t0, mem_cmd=2 at t1,
//    beats t1+L..t1+L+7, done_valid at t1+L+8. With wb: +BEATS send cycles + WB ack wait.
//  - Timeout: counter resets on entering WB_WAIT/RD_WAIT and on each captured beat; reaching TIMEOUT ->
//    DONE with done_err=1, done_data=0.
//  - req_valid while busy ignored (req_ready=0); req inputs need not be stable after acceptance.
//  - mem_resp in IDLE/WB_SEND/RD_CMD/DONE: ignored for state, sets proto_err.
// STRUCTURE
//  - cache_pkg: C2 command encodings (C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3),
//    LINE_BYTES, BUS_W, BEATS, state enum type.
//  - One sub-module line_serdes: LINE_BYTES*8 register with parallel load, beat select out (serialise)
//    and beat-indexed write (deserialise), shared by write-back and refill paths; FSM + counters here.
// TESTING
//  - Clean refill, memory L=3: req_rd_addr=0x012A, req_wb=0 -> mem_cmd=2 addr 0x012A for 1 cycle,
//    beats 0x0001..0x0008 -> done_data=0x0008_0007_..._0001, done_valid 1 cycle at t1+11.
//  - Dirty miss: req_wb=1, wb_addr=0x7FFF, wb_data=0xFFEE..0011 -> 8 cycles mem_cmd=3, mem_wdata 0x0011
//    first, 0xFFEE last; ack; then READ_LINE to rd_addr; done as above.
//  - Stalled burst: mem_resp drops for 2 cycles after beat 3 -> beats still in order, done 2 cycles later.
//  - Timeout: no mem_resp after READ_LINE -> done_valid=1, done_err=1 at TIMEOUT cycles, then IDLE.
//  - Reset mid-RD_DATA (beat 4): rst_n low async -> mem_cmd=0, req_ready=1 immediately; next request clean.
//  - Spurious mem_resp in IDLE -> proto_err=1, stays 1 across following requests until rst_n.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache <-> C2 bus line-transfer controller.
package cache_pkg;

   // Line geometry on the C2 bus
   localparam int LINE_BYTES = 16;
   localparam int BUS_W      = 16;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int BEATS      = LINE_W / BUS_W;

   // C2 bus command encodings
   typedef enum logic [1:0] {
      C2_NOP        = 2'd0,
      C2_RESPONSE   = 2'd1,
      C2_READ_LINE  = 2'd2,
      C2_WRITE_LINE = 2'd3
   } c2_cmd_e;

   // Miss-service sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB_SEND = 3'd1,
      ST_WB_WAIT = 3'd2,
      ST_RD_CMD  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   // States in which the memory is allowed to answer on the bus
   function automatic logic resp_expected(state_e s);
      return (s == ST_WB_WAIT) || (s == ST_RD_WAIT) || (s == ST_RD_DATA);
   endfunction

endpackage

// File: rtl/cache_mem_ctrl_line_serdes.sv
// Line buffer shared by write-back (serialise) and refill (deserialise).
// Parallel load of a whole line, beat-indexed read out, beat-indexed write in.
module line_serdes #(
   parameter  int NUM_LANES = 8,                   // beats per line
   parameter  int VEC_W     = 16,                  // bits per beat
   localparam int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clr,
   input  logic                                load,
   input  logic [NUM_LANES*VEC_W-1:0]          load_data,
   input  logic                                wr_en,
   input  logic [IDX_W-1:0]                    wr_idx,
   input  logic [VEC_W-1:0]                    wr_beat,
   input  logic [IDX_W-1:0]                    rd_idx,
   output logic [VEC_W-1:0]                    rd_beat,
   output logic [NUM_LANES-1:0][VEC_W-1:0]     line
);

   logic [NUM_LANES-1:0][VEC_W-1:0] line_q;

   // One register slot per beat; clear wins over load, load over beat write
   for (genvar b = 0; b < NUM_LANES; b++) begin : g_beat
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            line_q[b] <= '0;
         else if (clr)
            line_q[b] <= '0;
         else if (load)
            line_q[b] <= load_data[b*VEC_W +: VEC_W];
         else if (wr_en && (wr_idx == IDX_W'(b)))
            line_q[b] <= wr_beat;
      end
   end

   assign rd_beat = line_q[rd_idx];
   assign line    = line_q;

endmodule

// File: rtl/cache_mem_ctrl.sv
// Miss-service sequencer: optional dirty-victim write-back, then line refill,
// over the C2 bus. The cache core issues one request and waits for done.
module cache_mem_ctrl
   import cache_pkg::*;
#(
   parameter int LADDR_W = 15,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wb,
   input  logic [LADDR_W-1:0]   req_wb_addr,
   input  logic [LINE_W-1:0]    req_wb_data,
   input  logic [LADDR_W-1:0]   req_rd_addr,
   output logic                 done_valid,
   output logic                 done_err,
   output logic [LINE_W-1:0]    done_data,
   output logic [1:0]           mem_cmd,
   output logic [LADDR_W-1:0]   mem_addr,
   output logic [BUS_W-1:0]     mem_wdata,
   input  logic [BUS_W-1:0]     mem_rdata,
   input  logic                 mem_resp,
   output logic                 proto_err
);

   localparam int BW = $clog2(BEATS);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e                  state;
   c2_cmd_e                 mem_cmd_q;
   logic [BW-1:0]           beat_cnt;
   logic [TW-1:0]           tcnt;
   logic [LADDR_W-1:0]      rd_addr_q;

   logic                    accept;
   logic                    in_wait;
   logic                    capture;
   logic                    tmo;
   logic                    stray;
   logic [BUS_W-1:0]        wb_beat;
   logic [BEATS-1:0][BUS_W-1:0] line;

   // Handshake, beat capture, timeout and protocol-violation decode
   always_comb begin
      accept  = req_valid && req_ready;
      in_wait = resp_expected(state);
      capture = mem_resp && ((state == ST_RD_WAIT) || (state == ST_RD_DATA));
      tmo     = in_wait && !mem_resp && (tcnt == TW'(TIMEOUT - 1));
      stray   = mem_resp && !in_wait;
   end

   line_serdes #(
      .NUM_LANES (BEATS),
      .VEC_W     (BUS_W)
   ) u_serdes (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (tmo),
      .load      (accept),
      .load_data (req_wb_data),
      .wr_en     (capture),
      .wr_idx    (beat_cnt),
      .wr_beat   (mem_rdata),
      .rd_idx    (beat_cnt),
      .rd_beat   (wb_beat),
      .line      (line)
   );

   // Sequencer: state, counters and all registered bus/handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
         mem_cmd_q  <= C2_NOP;
         mem_addr   <= '0;
         beat_cnt   <= '0;
         tcnt       <= '0;
         rd_addr_q  <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (stray)
            proto_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  rd_addr_q <= req_rd_addr;
                  beat_cnt  <= '0;
                  if (req_wb) begin
                     state     <= ST_WB_SEND;
                     mem_cmd_q <= C2_WRITE_LINE;
                     mem_addr  <= req_wb_addr;
                  end else begin
                     state     <= ST_RD_CMD;
                     mem_cmd_q <= C2_READ_LINE;
                     mem_addr  <= req_rd_addr;
                  end
               end
            end

            ST_WB_SEND: begin
               if (beat_cnt == BW'(BEATS - 1)) begin
                  state     <= ST_WB_WAIT;
                  mem_cmd_q <= C2_NOP;
                  mem_addr  <= '0;
                  beat_cnt  <= '0;
                  tcnt      <= '0;
               end else begin
                  beat_cnt <= beat_cnt + BW'(1);
               end
            end

            ST_WB_WAIT: begin
               if (mem_resp) begin
                  state     <= ST_RD_CMD;
                  mem_cmd_q <= C2_READ_LINE;
                  mem_addr  <= rd_addr_q;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            ST_RD_CMD: begin
               state     <= ST_RD_WAIT;
               mem_cmd_q <= C2_NOP;
               mem_addr  <= '0;
               tcnt      <= '0;
            end

            ST_RD_WAIT: begin
               if (mem_resp) begin
                  state    <= ST_RD_DATA;
                  beat_cnt <= BW'(1);
                  tcnt     <= '0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            ST_RD_DATA: begin
               if (mem_resp) begin
                  tcnt <= '0;
                  if (beat_cnt == BW'(BEATS - 1)) begin
                     state      <= ST_DONE;
                     done_valid <= 1'b1;
                     done_err   <= 1'b0;
                     beat_cnt   <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            ST_DONE: begin
               done_valid <= 1'b0;
               done_err   <= 1'b0;
               req_ready  <= 1'b1;
               state      <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase

         // Abort overrides whatever the wait state chose; the line buffer is
         // cleared in the same edge so done_data reads back as zero
         if (tmo) begin
            state      <= ST_DONE;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            mem_cmd_q  <= C2_NOP;
            mem_addr   <= '0;
            beat_cnt   <= '0;
            tcnt       <= '0;
         end
      end
   end

   assign mem_cmd   = mem_cmd_q;
   assign mem_wdata = (mem_cmd_q == C2_WRITE_LINE) ? wb_beat : '0;
   assign done_data = done_valid ? line : '0;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench: stimulus pushes expectations from a line-memory model,
// a bus responder and a done monitor pop and compare independently.
module tb_cache_mem_ctrl;
   import cache_pkg::*;

   localparam int AW  = 15;
   localparam int LW  = LINE_BYTES * 8;
   localparam int NB  = BEATS;
   localparam int TMO = 1023;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid, req_ready, req_wb;
   logic [AW-1:0]   req_wb_addr, req_rd_addr;
   logic [LW-1:0]   req_wb_data;
   logic            done_valid, done_err;
   logic [LW-1:0]   done_data;
   logic [1:0]      mem_cmd;
   logic [AW-1:0]   mem_addr;
   logic [BUS_W-1:0] mem_wdata, mem_rdata;
   logic            mem_resp;
   logic            proto_err;

   cache_mem_ctrl #(.LADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
      .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_rd_addr(req_rd_addr),
      .done_valid(done_valid), .done_err(done_err), .done_data(done_data),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic err; logic [LW-1:0] data; } done_t;
   typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } wb_t;
   typedef struct { int lat; int stall_at; int stall_len; bit no_resp; int ack_dly; int rst_beat; } cfg_t;

   done_t          exp_done_q[$];
   wb_t            exp_wb_q[$];
   logic [AW-1:0]  exp_rd_q[$];
   int             start_q[$];
   int             done_cyc_q[$];
   cfg_t           cfg_q[$];

   logic [LW-1:0]  ref_mem [logic [AW-1:0]];   // what memory should hold
   logic [LW-1:0]  phy_mem [logic [AW-1:0]];   // what the DUT actually wrote

   int  checks = 0, errors = 0;
   bit  proto_exp = 0;
   int  spur_cnt = 0, spur_done = 0, hit_cnt = 0;
   bit  wb_pending = 0;
   int  exp_rd_cyc = 0;

   function automatic logic [LW-1:0] init_line(logic [AW-1:0] a);
      logic [LW-1:0] l;
      for (int k = 0; k < NB; k++)
         l[k*BUS_W +: BUS_W] = (16'(a) * 16'h9E37) ^ (16'(k) * 16'h1111) ^ 16'h5A5A;
      return l;
   endfunction

   function automatic logic [LW-1:0] ref_get(logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   function automatic logic [LW-1:0] phy_get(logic [AW-1:0] a);
      return phy_mem.exists(a) ? phy_mem[a] : init_line(a);
   endfunction

   function automatic cfg_t mk_cfg(int lat, int sa, int sl, bit nr, int ack, int rb);
      cfg_t c;
      c.lat = lat; c.stall_at = sa; c.stall_len = sl; c.no_resp = nr; c.ack_dly = ack; c.rst_beat = rb;
      return c;
   endfunction

   task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic miss(string name);
      checks++;
      errors++;
      $display("FAIL %s: expectation missing or wait expired (cycle %0d)", name, cyc);
   endtask

   // ---------------- memory responder ----------------
   task automatic do_write();
      logic [AW-1:0] a;
      logic [LW-1:0] got;
      bit            shape_ok;
      wb_t           e;
      cfg_t          c;
      if (start_q.size() > 0) chk("wb_start_cycle", cyc, start_q.pop_front());
      else miss("wb_start_cycle");
      a = mem_addr;
      shape_ok = 1;
      for (int k = 0; k < NB; k++) begin
         if (k > 0) @(negedge clk);
         if (mem_cmd !== C2_WRITE_LINE || mem_addr !== a) shape_ok = 0;
         got[k*BUS_W +: BUS_W] = mem_wdata;
      end
      @(negedge clk);
      chk("wb_burst_len", {mem_cmd, 7'(shape_ok)}, {C2_NOP, 7'd1});
      if (exp_wb_q.size() > 0) begin
         e = exp_wb_q.pop_front();
         chk("wb_addr", a, e.addr);
         chk("wb_data", got, e.data);
      end else miss("wb_expect");
      phy_mem[a] = got;
      c = (cfg_q.size() > 0) ? cfg_q[0] : mk_cfg(1, 0, 0, 0, 0, -1);
      repeat (c.ack_dly) @(negedge clk);
      mem_resp   = 1'b1;
      exp_rd_cyc = cyc + 1;
      wb_pending = 1;
   endtask

   task automatic do_read();
      int            c0;
      cfg_t          c;
      logic [LW-1:0] line;
      c0 = cyc;
      if (wb_pending) begin
         chk("rd_after_ack_cycle", cyc, exp_rd_cyc);
         wb_pending = 0;
      end else if (start_q.size() > 0) chk("rd_start_cycle", cyc, start_q.pop_front());
      else miss("rd_start_cycle");
      if (exp_rd_q.size() > 0) chk("rd_addr", mem_addr, exp_rd_q.pop_front());
      else miss("rd_addr");
      line = phy_get(mem_addr);
      c = (cfg_q.size() > 0) ? cfg_q.pop_front() : mk_cfg(1, 0, 0, 0, 0, -1);
      @(negedge clk);
      chk("rd_cmd_one_cycle", mem_cmd, C2_NOP);
      if (c.no_resp) begin
         done_cyc_q.push_back(c0 + TMO + 1);
         return;
      end
      repeat (c.lat - 1) @(negedge clk);
      for (int k = 0; k < NB; k++) begin
         if (k == c.rst_beat) begin
            mem_resp = 1'b0;
            hit_cnt++;
            wait (!rst_n);
            wait (rst_n);
            return;
         end
         if (c.stall_len > 0 && k == c.stall_at + 1) begin
            mem_resp = 1'b0;
            repeat (c.stall_len) @(negedge clk);
         end
         mem_resp  = 1'b1;
         mem_rdata = line[k*BUS_W +: BUS_W];
         if (k < NB - 1) @(negedge clk);
      end
      done_cyc_q.push_back(cyc + 1);
   endtask

   initial begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp  = 1'b0;
         mem_rdata = '0;
         if (rst_n) begin
            if (spur_done < spur_cnt) begin
               spur_done++;
               mem_resp  = 1'b1;
               mem_rdata = 16'hDEAD;
            end else if (mem_cmd == C2_WRITE_LINE) do_write();
            else if (mem_cmd == C2_READ_LINE) do_read();
         end
      end
   end

   // ---------------- done monitor ----------------
   initial begin
      bit    prev_dv;
      done_t d;
      prev_dv = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) prev_dv = 0;
         else begin
            if (done_valid) begin
               chk("done_single_pulse", 128'(prev_dv), 128'd0);
               if (exp_done_q.size() > 0) begin
                  d = exp_done_q.pop_front();
                  chk("done_err", 128'(done_err), 128'(d.err));
                  chk("done_data", done_data, d.data);
               end else miss("done_unexpected");
               if (done_cyc_q.size() > 0) chk("done_cycle", cyc, done_cyc_q.pop_front());
               else miss("done_cycle");
               chk("proto_err_at_done", 128'(proto_err), 128'(proto_exp));
            end
            prev_dv = done_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(bit wb, logic [AW-1:0] wba, logic [LW-1:0] wbd,
                        logic [AW-1:0] rda, cfg_t c, bit wait_done);
      int    n;
      done_t d;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 3000) begin @(negedge clk); n++; end
      if (!req_ready) begin miss("req_ready_wait"); return; end
      req_valid = 1'b1; req_wb = wb; req_wb_addr = wba; req_wb_data = wbd; req_rd_addr = rda;
      start_q.push_back(cyc + 1);
      cfg_q.push_back(c);
      exp_rd_q.push_back(rda);
      if (wb) begin
         exp_wb_q.push_back('{addr: wba, data: wbd});
         ref_mem[wba] = wbd;
      end
      d.err  = c.no_resp;
      d.data = c.no_resp ? '0 : ref_get(rda);
      exp_done_q.push_back(d);
      @(negedge clk);
      chk("ready_low_after_accept", 128'(req_ready), 128'd0);
      if (!wait_done) begin req_valid = 1'b0; return; end
      n = 0;
      // Busy: throw ignored requests with garbage at the controller
      while (!req_ready && n < 3000) begin
         req_valid   = 1'($urandom_range(1, 0));
         req_wb      = 1'($urandom_range(1, 0));
         req_wb_addr = AW'($urandom);
         req_rd_addr = AW'($urandom);
         req_wb_data = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      if (!req_ready) miss("done_wait");
   endtask

   task automatic rand_req();
      bit            wb;
      logic [AW-1:0] wba, rda;
      wb  = 1'($urandom_range(1, 0));
      wba = AW'(15'h0010 + $urandom_range(7, 0));
      rda = AW'(15'h0010 + $urandom_range(7, 0));
      issue(wb, wba, {$urandom, $urandom, $urandom, $urandom}, rda,
            mk_cfg($urandom_range(5, 1), $urandom_range(6, 0), $urandom_range(3, 0), 0,
                   $urandom_range(4, 0), -1), 1);
   endtask

   initial begin
      logic [LW-1:0] l0;
      int h, n;
      req_valid = 0; req_wb = 0; req_wb_addr = '0; req_wb_data = '0; req_rd_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 128'(req_ready), 128'd1);
      chk("rst_mem_cmd", 128'(mem_cmd), 128'd0);
      chk("rst_mem_addr", 128'(mem_addr), 128'd0);
      chk("rst_mem_wdata", 128'(mem_wdata), 128'd0);
      chk("rst_done_valid", 128'(done_valid), 128'd0);
      chk("rst_done_err", 128'(done_err), 128'd0);
      chk("rst_done_data", done_data, 128'd0);
      chk("rst_proto_err", 128'(proto_err), 128'd0);
      rst_n = 1'b1;

      for (int k = 0; k < NB; k++) l0[k*BUS_W +: BUS_W] = 16'(k + 1);
      ref_mem[15'h012A] = l0;
      phy_mem[15'h012A] = l0;

      // clean refill, L=3
      issue(0, '0, '0, 15'h012A, mk_cfg(3, 0, 0, 0, 0, -1), 1);
      // dirty miss, write-back then refill
      issue(1, 15'h7FFF, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_0011, 15'h012A,
            mk_cfg(3, 0, 0, 0, 2, -1), 1);
      // refill of the line just written back
      issue(0, '0, '0, 15'h7FFF, mk_cfg(1, 0, 0, 0, 0, -1), 1);
      // stall 2 cycles after beat 3
      issue(0, '0, '0, 15'h0155, mk_cfg(2, 3, 2, 0, 0, -1), 1);
      // timeout with no response
      issue(0, '0, '0, 15'h0033, mk_cfg(2, 0, 0, 1, 0, -1), 1);

      // async reset in the middle of the refill burst (before beat 4)
      h = hit_cnt;
      issue(0, '0, '0, 15'h0044, mk_cfg(2, 0, 0, 0, 0, 4), 0);
      n = 0;
      while (hit_cnt == h && n < 200) begin @(negedge clk); n++; end
      if (hit_cnt == h) miss("reach_beat4");
      #2 rst_n = 1'b0;
      proto_exp = 0;
      #1;
      chk("midrst_mem_cmd", 128'(mem_cmd), 128'd0);
      chk("midrst_req_ready", 128'(req_ready), 128'd1);
      chk("midrst_done_valid", 128'(done_valid), 128'd0);
      if (exp_done_q.size() > 0) void'(exp_done_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, '0, '0, 15'h0044, mk_cfg(2, 0, 0, 0, 0, -1), 1);

      for (int i = 0; i < 20; i++) rand_req();

      // spurious response while idle: sticky until reset
      @(negedge clk);
      spur_cnt++;
      proto_exp = 1;
      repeat (3) @(negedge clk);
      chk("proto_err_set", 128'(proto_err), 128'd1);
      for (int i = 0; i < 3; i++) rand_req();
      repeat (2) @(negedge clk);
      chk("proto_err_sticky", 128'(proto_err), 128'd1);
      rst_n = 1'b0;
      proto_exp = 0;
      #1;
      chk("proto_err_cleared", 128'(proto_err), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      chk("done_queue_drained", 128'(exp_done_q.size()), 128'd0);
      chk("wb_queue_drained", 128'(exp_wb_q.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
